// File: rtl/alpha_blend_pipe.sv
// alpha_blend_pipe
//   Pipelined alpha blender between the rasteriser pixel stream and the
//   framebuffer memory controller. Each accepted source pixel issues a
//   framebuffer read. RD_LAT cycles later the returned destination colour is
//   blended with the source (over / additive / replace / multiply). The
//   result is queued in a small FIFO that drives the write-back beats.
//   Admission is credit based, so the FIFO can never overflow.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   in_valid/ready  source pixel handshake
//   in_addr         framebuffer pixel address
//   in_rgb, in_a    source colour (channel 0 in LSBs) and alpha
//   in_mode         00 over, 01 additive, 10 replace, 11 multiply
//   in_last         last pixel of frame
//   rd_en/rd_addr   framebuffer read strobe / address
//   rd_data         destination colour, valid RD_LAT cycles after rd_en
//   wr_valid/ready  write-back beat handshake
//   wr_addr/data    write address / blended colour
//   wr_last         last pixel of frame
//   frame_done      one-cycle pulse after the wr_last beat is written
module alpha_blend_pipe #(
   parameter int CW         = 8,
   parameter int NCH        = 3,
   parameter int AW         = 19,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AW-1:0]     in_addr,
   input  logic [NCH*CW-1:0] in_rgb,
   input  logic [CW-1:0]     in_a,
   input  logic [1:0]        in_mode,
   input  logic              in_last,
   output logic              rd_en,
   output logic [AW-1:0]     rd_addr,
   input  logic [NCH*CW-1:0] rd_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [AW-1:0]     wr_addr,
   output logic [NCH*CW-1:0] wr_data,
   output logic              wr_last,
   output logic              frame_done
);

   localparam int DW    = NCH * CW;
   localparam int PW    = 2 * CW + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CW-1:0] MAX    = {CW{1'b1}};
   localparam logic [PW-1:0] MAX_W  = {{(CW+1){1'b0}}, MAX};
   localparam logic [PW-1:0] HALF_W = MAX_W >> 1;

   localparam logic [1:0] MODE_OVER = 2'b00;
   localparam logic [1:0] MODE_ADD  = 2'b01;
   localparam logic [1:0] MODE_REPL = 2'b10;
   localparam logic [1:0] MODE_MUL  = 2'b11;

   // Rounded division by MAX; the quotient always fits in CW bits.
   function automatic logic [CW-1:0] div_max(input logic [PW-1:0] x);
      return CW'((x + HALF_W) / MAX_W);
   endfunction

   function automatic logic [CW-1:0] sat_max(input logic [CW:0] sum);
      return (sum > {1'b0, MAX}) ? MAX : sum[CW-1:0];
   endfunction

   function automatic logic [CW-1:0] blend_chan(input logic [CW-1:0] s,
                                                input logic [CW-1:0] d,
                                                input logic [CW-1:0] a,
                                                input logic [1:0]    mode);
      logic [PW-1:0] s_w, d_w, a_w, na_w;
      logic [CW-1:0] result;
      s_w    = {{(CW+1){1'b0}}, s};
      d_w    = {{(CW+1){1'b0}}, d};
      a_w    = {{(CW+1){1'b0}}, a};
      na_w   = {{(CW+1){1'b0}}, MAX - a};
      result = s;
      case (mode)
         MODE_OVER: result = div_max(s_w * a_w + d_w * na_w);
         MODE_ADD:  result = sat_max({1'b0, d} + {1'b0, div_max(s_w * a_w)});
         MODE_REPL: result = s;
         MODE_MUL:  result = div_max(s_w * d_w);
      endcase
      return result;
   endfunction

   logic             accept, push, pop;
   logic [CNT_W-1:0] inflight, fifo_count;
   logic [PTR_W-1:0] wptr, rptr;

   logic             vld_p  [RD_LAT];
   logic [AW-1:0]    addr_p [RD_LAT];
   logic [DW-1:0]    rgb_p  [RD_LAT];
   logic [CW-1:0]    a_p    [RD_LAT];
   logic [1:0]       mode_p [RD_LAT];
   logic             last_p [RD_LAT];

   logic [AW-1:0]    fifo_addr [FIFO_DEPTH];
   logic [DW-1:0]    fifo_data [FIFO_DEPTH];
   logic             fifo_last [FIFO_DEPTH];

   logic [DW-1:0]    blend_rgb;

   // ---- accept stage: credits cover both in-flight reads and queued results
   assign in_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH);
   assign accept   = in_valid && in_ready;
   assign rd_en    = accept;
   assign rd_addr  = in_addr;

   // ---- side pipeline stages 0..RD_LAT-1, last stage aligned with rd_data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < RD_LAT; k++) vld_p[k] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int k = 1; k < RD_LAT; k++) vld_p[k] <= vld_p[k-1];
      end
   end

   always_ff @(posedge clk) begin
      addr_p[0] <= in_addr;
      rgb_p[0]  <= in_rgb;
      a_p[0]    <= in_a;
      mode_p[0] <= in_mode;
      last_p[0] <= in_last;
      for (int k = 1; k < RD_LAT; k++) begin
         addr_p[k] <= addr_p[k-1];
         rgb_p[k]  <= rgb_p[k-1];
         a_p[k]    <= a_p[k-1];
         mode_p[k] <= mode_p[k-1];
         last_p[k] <= last_p[k-1];
      end
   end

   // ---- blend stage RD_LAT: combine with returned destination, push to FIFO
   always_comb begin
      blend_rgb = '0;
      for (int c = 0; c < NCH; c++) begin
         blend_rgb[c*CW +: CW] = blend_chan(rgb_p[RD_LAT-1][c*CW +: CW],
                                            rd_data[c*CW +: CW],
                                            a_p[RD_LAT-1], mode_p[RD_LAT-1]);
      end
   end

   assign push = vld_p[RD_LAT-1];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wptr] <= addr_p[RD_LAT-1];
         fifo_data[wptr] <= blend_rgb;
         fifo_last[wptr] <= last_p[RD_LAT-1];
      end
   end

   // ---- output stage: FIFO head drives the write-back beat
   assign wr_valid = (fifo_count != '0);
   assign pop      = wr_valid && wr_ready;
   assign wr_addr  = wr_valid ? fifo_addr[rptr] : '0;
   assign wr_data  = wr_valid ? fifo_data[rptr] : '0;
   assign wr_last  = wr_valid && fifo_last[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight   <= '0;
         fifo_count <= '0;
         wptr       <= '0;
         rptr       <= '0;
         frame_done <= 1'b0;
      end else begin
         if (accept && !push)      inflight <= inflight + CNT_W'(1);
         else if (!accept && push) inflight <= inflight - CNT_W'(1);

         if (push && !pop)         fifo_count <= fifo_count + CNT_W'(1);
         else if (!push && pop)    fifo_count <= fifo_count - CNT_W'(1);

         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);

         frame_done <= pop && fifo_last[rptr];
      end
   end

endmodule

// File: tb/tb_alpha_blend_pipe.sv
module tb_alpha_blend_pipe;

   localparam int CW         = 8;
   localparam int NCH        = 3;
   localparam int AW         = 19;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int DW         = NCH * CW;
   localparam int MAXV       = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid, in_ready, in_last;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_rgb;
   logic [CW-1:0] in_a;
   logic [1:0]    in_mode;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_valid, wr_ready, wr_last, frame_done;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
      int            cyc;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    acc_cyc_q[$];
   int    fd_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    stall_viol = 0;
   bit    send_done;

   logic [DW-1:0] fb_mem [256];
   logic [DW-1:0] rq [RD_LAT];

   alpha_blend_pipe #(
      .CW(CW), .NCH(NCH), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_rgb(in_rgb), .in_a(in_a), .in_mode(in_mode), .in_last(in_last),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_last(wr_last), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Framebuffer model: returns fb_mem contents RD_LAT cycles after a read,
   // garbage otherwise.
   always @(posedge clk) begin
      rq[0] <= rd_en ? fb_mem[rd_addr[7:0]] : DW'($urandom);
      for (int k = 1; k < RD_LAT; k++) rq[k] <= rq[k-1];
   end
   assign rd_data = rq[RD_LAT-1];

   // Write-side observer: logs popped beats, frame_done pulses and stall holds.
   initial begin : monitor
      beat_t         b;
      bit            stall_pend;
      logic [AW-1:0] st_addr;
      logic [DW-1:0] st_data;
      logic          st_last;
      stall_pend = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall_pend = 0;
         end else begin
            if (stall_pend && (wr_valid !== 1'b1 || wr_addr !== st_addr ||
                               wr_data !== st_data || wr_last !== st_last))
               stall_viol++;
            stall_pend = wr_valid && !wr_ready;
            st_addr = wr_addr;
            st_data = wr_data;
            st_last = wr_last;
            if (wr_valid && wr_ready) begin
               b.addr = wr_addr; b.data = wr_data; b.last = wr_last; b.cyc = cyc;
               obs_q.push_back(b);
            end
            if (frame_done) fd_q.push_back(cyc);
         end
      end
   end

   // Reference blend, straight from the per-channel arithmetic rules.
   function automatic int ref_chan(int s, int d, int a, int mode);
      int t;
      case (mode)
         0: return (s * a + d * (MAXV - a) + MAXV / 2) / MAXV;
         1: begin
            t = d + (s * a + MAXV / 2) / MAXV;
            return (t > MAXV) ? MAXV : t;
         end
         2: return s;
         default: return (s * d + MAXV / 2) / MAXV;
      endcase
   endfunction

   function automatic logic [DW-1:0] ref_pixel(logic [DW-1:0] s, logic [DW-1:0] d,
                                                logic [CW-1:0] a, logic [1:0] mode);
      logic [DW-1:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++)
         r[c*CW +: CW] = CW'(ref_chan(int'(s[c*CW +: CW]), int'(d[c*CW +: CW]),
                                      int'(a), int'(mode)));
      return r;
   endfunction

   task automatic clear_queues();
      exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); fd_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one pixel (called at posedge+1) and holds it until accepted.
   task automatic send_pixel(input logic [AW-1:0] addr, input logic [DW-1:0] rgb,
                             input logic [CW-1:0] a, input logic [1:0] mode,
                             input logic last);
      int    n;
      beat_t e;
      in_valid = 1'b1; in_addr = addr; in_rgb = rgb;
      in_a = a; in_mode = mode; in_last = last;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_accept addr=%h: in_ready low for %0d cycles, required accept", addr, n);
      end else begin
         e.addr = addr;
         e.data = ref_pixel(rgb, fb_mem[addr[7:0]], a, mode);
         e.last = last;
         e.cyc  = cyc;
         exp_q.push_back(e);
         acc_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_random(input int n);
      for (int i = 0; i < n; i++)
         send_pixel(AW'($urandom), DW'($urandom), CW'($urandom),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
   endtask

   task automatic wait_obs(input int n, output bit timed_out);
      int k;
      k = 0;
      while (obs_q.size() < n && k < 500) begin
         @(posedge clk);
         k++;
      end
      #1;
      timed_out = (obs_q.size() < n);
   endtask

   task automatic test_reset();
      in_valid = 1'b0; wr_ready = 1'b0;
      #1 reset = 1'b0;
      tick(2);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL reset_wr_valid got %b want 0", wr_valid); end
      total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
      total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
      total++; if (wr_last !== 1'b0) begin bad++; $display("FAIL reset_wr_last got %b want 0", wr_last); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      reset = 1'b1;
      tick(1);
      total++; if (in_ready !== 1'b1 || wr_valid !== 1'b0) begin
         bad++; $display("FAIL post_reset got in_ready=%b wr_valid=%b want 1/0", in_ready, wr_valid);
      end
   endtask

   task automatic test_blend_modes();
      int ts[6] = '{255, 255, 200, 100, 128, 77};
      int td[6] = '{0,   33,  33,  200, 128, 9};
      int ta[6] = '{128, 0,   255, 255, 7,   50};
      int tm[6] = '{0,   0,   0,   1,   3,   2};
      int tw[6] = '{128, 33,  200, 255, 64,  77};
      logic [AW-1:0] addr;
      logic [CW-1:0] w;
      logic [DW-1:0] want;
      bit            to;
      wr_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         clear_queues();
         addr = AW'(32'h21000 + i);
         fb_mem[addr[7:0]] = {NCH{CW'(td[i])}};
         send_pixel(addr, {NCH{CW'(ts[i])}}, CW'(ta[i]), 2'(tm[i]), 1'b0);
         wait_obs(1, to);
         w = CW'(tw[i]);
         want = {NCH{w}};
         total++;
         if (to) begin
            bad++; $display("FAIL blend_case%0d no write beat, want data=%h", i, want);
         end else begin
            if (obs_q[0].data !== want || obs_q[0].addr !== addr) begin
               bad++;
               $display("FAIL blend_case%0d got addr=%h data=%h want addr=%h data=%h",
                        i, obs_q[0].addr, obs_q[0].data, addr, want);
            end
            total++;
            if (obs_q[0].cyc - acc_cyc_q[0] !== RD_LAT + 1) begin
               bad++;
               $display("FAIL latency_case%0d got %0d cycles want %0d",
                        i, obs_q[0].cyc - acc_cyc_q[0], RD_LAT + 1);
            end
         end
      end
   endtask

   task automatic test_stream();
      bit to;
      int n;
      n = 40;
      clear_queues();
      wr_ready = 1'b1;
      send_random(n);
      wait_obs(n, to);
      tick(5);
      total++; if (obs_q.size() !== n) begin bad++; $display("FAIL stream_count got %0d want %0d", obs_q.size(), n); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
             obs_q[i].last !== exp_q[i].last) begin
            bad++;
            $display("FAIL stream_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr,
                     obs_q[i].data, obs_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
         end
      end
      if (obs_q.size() == n && acc_cyc_q.size() == n) begin
         total++;
         if (acc_cyc_q[n-1] - acc_cyc_q[0] !== n - 1) begin
            bad++; $display("FAIL stream_accept_rate got span %0d want %0d", acc_cyc_q[n-1] - acc_cyc_q[0], n - 1);
         end
         total++;
         if (obs_q[n-1].cyc - obs_q[0].cyc !== n - 1) begin
            bad++; $display("FAIL stream_write_rate got span %0d want %0d", obs_q[n-1].cyc - obs_q[0].cyc, n - 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit to;
      clear_queues();
      wr_ready = 1'b0;
      fork
         send_random(16);
         begin
            tick(12);
            total++; if (acc_cyc_q.size() !== FIFO_DEPTH) begin
               bad++; $display("FAIL burst_accepts got %0d want %0d", acc_cyc_q.size(), FIFO_DEPTH);
            end
            total++; if (in_ready !== 1'b0 || wr_valid !== 1'b1) begin
               bad++; $display("FAIL burst_stalled got in_ready=%b wr_valid=%b want 0/1", in_ready, wr_valid);
            end
            total++; if (obs_q.size() !== 0) begin
               bad++; $display("FAIL burst_no_write got %0d beats want 0", obs_q.size());
            end
            wr_ready = 1'b1;
         end
      join
      wait_obs(16, to);
      tick(5);
      total++; if (obs_q.size() !== 16) begin bad++; $display("FAIL burst_count got %0d want 16", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
             obs_q[i].last !== exp_q[i].last) begin
            bad++;
            $display("FAIL burst_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr,
                     obs_q[i].data, obs_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_toggle_stall();
      bit to;
      clear_queues();
      stall_viol = 0;
      send_done = 0;
      wr_ready = 1'b0;
      fork
         begin
            send_random(30);
            send_done = 1;
         end
         begin
            int k;
            k = 0;
            while (!send_done && k < 1000) begin
               @(posedge clk);
               #1;
               wr_ready = ~wr_ready;
               k++;
            end
         end
      join
      wr_ready = 1'b1;
      wait_obs(30, to);
      tick(5);
      total++; if (obs_q.size() !== 30) begin bad++; $display("FAIL toggle_count got %0d want 30", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
             obs_q[i].last !== exp_q[i].last) begin
            bad++;
            $display("FAIL toggle_beat%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].addr,
                     obs_q[i].data, obs_q[i].last, exp_q[i].addr, exp_q[i].data, exp_q[i].last);
         end
      end
      total++; if (stall_viol !== 0) begin bad++; $display("FAIL toggle_hold got %0d changes while stalled want 0", stall_viol); end
   endtask

   task automatic test_frame();
      bit to;
      clear_queues();
      wr_ready = 1'b1;
      for (int i = 0; i < 7; i++)
         send_pixel(AW'(32'h30000 + i * 7), DW'($urandom), CW'($urandom),
                    2'($urandom_range(0, 3)), (i == 4));
      wait_obs(7, to);
      tick(4);
      total++; if (obs_q.size() !== 7) begin bad++; $display("FAIL frame_count got %0d want 7", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].last !== (i == 4) || obs_q[i].data !== exp_q[i].data) begin
            bad++;
            $display("FAIL frame_beat%0d got last=%b data=%h want last=%b data=%h",
                     i, obs_q[i].last, obs_q[i].data, (i == 4), exp_q[i].data);
         end
      end
      total++; if (fd_q.size() !== 1) begin bad++; $display("FAIL frame_done_pulses got %0d want 1", fd_q.size()); end
      if (fd_q.size() > 0 && obs_q.size() > 4) begin
         total++;
         if (fd_q[0] !== obs_q[4].cyc + 1) begin
            bad++; $display("FAIL frame_done_cycle got %0d want %0d", fd_q[0], obs_q[4].cyc + 1);
         end
      end
   endtask

   task automatic test_reset_midflight();
      bit to;
      clear_queues();
      wr_ready = 1'b0;
      send_random(FIFO_DEPTH);
      #1 reset = 1'b0;
      #1;
      total++; if (wr_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL midreset_async got wr_valid=%b in_ready=%b want 0/1", wr_valid, in_ready);
      end
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      total++; if (wr_valid !== 1'b0 || in_ready !== 1'b1 || wr_data !== '0) begin
         bad++; $display("FAIL midreset_release got wr_valid=%b in_ready=%b wr_data=%h want 0/1/0",
                         wr_valid, in_ready, wr_data);
      end
      @(posedge clk);
      #1;
      clear_queues();
      wr_ready = 1'b1;
      tick(10);
      total++; if (obs_q.size() !== 0 || fd_q.size() !== 0) begin
         bad++; $display("FAIL midreset_stale got %0d beats %0d frame_done want 0/0", obs_q.size(), fd_q.size());
      end
      send_random(3);
      wait_obs(3, to);
      tick(3);
      total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL recover_count got %0d want 3", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
            bad++;
            $display("FAIL recover_beat%0d got %h/%h want %h/%h", i, obs_q[i].addr,
                     obs_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      in_valid = 1'b0; in_addr = '0; in_rgb = '0; in_a = '0;
      in_mode = 2'b00; in_last = 1'b0; wr_ready = 1'b0;
      for (int i = 0; i < 256; i++) fb_mem[i] = DW'($urandom);
      test_reset();
      test_blend_modes();
      test_stream();
      test_back_to_back();
      test_toggle_stall();
      test_frame();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
